// File: rtl/alarm_register_bank_pkg.sv
// -----------------------------------------------------------------------------
// alarm_register_bank_pkg
// Shared constants and types for the alarm register bank.
//   WIDTH : bits per stored alarm/time word
//   DEPTH : number of alarm slots (2..16)
//   AW    : slot address width, derived from DEPTH
// The package also holds the scan-index wrap helper.
// -----------------------------------------------------------------------------
package alarm_register_bank_pkg;

    localparam int WIDTH = 13;
    localparam int DEPTH = 7;
    localparam int AW    = $clog2(DEPTH);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [AW-1:0]    idx_t;

    // DEPTH is held in AW+1 bits so that DEPTH=16 (a power of two) still
    // compares correctly against an AW-bit address.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // Next scan position, wrapping DEPTH-1 -> 0.
    function automatic idx_t next_idx(input idx_t i);
        if ({1'b0, i} == DEPTH_W - (AW+1)'(1)) begin
            return '0;
        end
        return i + idx_t'(1);
    endfunction

endpackage

// File: rtl/alarm_register_bank_if.sv
// -----------------------------------------------------------------------------
// alarm_register_bank_if
// Groups the write/erase strobes, the time input and all status outputs of
// the alarm register bank.
//   master : drives Enable, Erase, STO, D, Time; observes the outputs
//   slave  : the bank itself
// -----------------------------------------------------------------------------
interface alarm_register_bank_if;
    import alarm_register_bank_pkg::*;

    logic                     Enable;
    logic                     Erase;
    idx_t                     STO;
    word_t                    D;
    word_t                    Time;
    logic [DEPTH*WIDTH-1:0]   Q_flat;
    logic [DEPTH-1:0]         Valid;
    logic                     Match;
    idx_t                     Match_idx;
    idx_t                     Scan_idx;

    modport master (
        output Enable, Erase, STO, D, Time,
        input  Q_flat, Valid, Match, Match_idx, Scan_idx
    );

    modport slave (
        input  Enable, Erase, STO, D, Time,
        output Q_flat, Valid, Match, Match_idx, Scan_idx
    );

endinterface

// File: rtl/alarm_register_bank_slot.sv
// -----------------------------------------------------------------------------
// alarm_slot
// One alarm slot: a WIDTH-bit word plus valid and fired flags.
//   clk, rst    : clock, asynchronous active-high reset
//   wr_en       : store wr_data, set valid, clear fired
//   erase       : clear valid and fired (data kept); beats wr_en on valid
//   scan_hit    : this slot matched during its scan cycle -> set fired
//   scan_rearm  : this slot was scanned, valid, and differs from Time
//   data, valid, fired : current slot state
// -----------------------------------------------------------------------------
module alarm_slot
    import alarm_register_bank_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  logic  erase,
    input  logic  scan_hit,
    input  logic  scan_rearm,
    input  word_t wr_data,
    output word_t data,
    output logic  valid,
    output logic  fired
);

    word_t data_q,  data_d;
    logic  valid_q, valid_d;
    logic  fired_q, fired_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fired_d = fired_q;

        if (scan_hit) begin
            fired_d = 1'b1;
        end else if (scan_rearm) begin
            fired_d = 1'b0;
        end

        // Host writes/erases override the scan's update of fired.
        if (wr_en) begin
            data_d  = wr_data;
            valid_d = 1'b1;
            fired_d = 1'b0;
        end
        if (erase) begin
            valid_d = 1'b0;
            fired_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fired_q <= fired_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign fired = fired_q;

endmodule

// File: rtl/alarm_register_bank.sv
// -----------------------------------------------------------------------------
// alarm_register_bank
// DEPTH alarm slots continuously scanned one per cycle against Time. A valid,
// un-fired slot equal to Time raises Match for one cycle (latency 1) with its
// index on Match_idx, then stays quiet until Time moves away from it.
//   Clock : clock
//   Clear : asynchronous active-high reset
//   bus   : write/erase strobes, address, data, Time, and all status outputs
// -----------------------------------------------------------------------------
module alarm_register_bank
    import alarm_register_bank_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Clear,
    alarm_register_bank_if.slave  bus
);

    idx_t  scan_q,      scan_d;
    logic  match_q,     match_d;
    idx_t  match_idx_q, match_idx_d;

    word_t            slot_data [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_fired;

    logic  sto_ok;
    word_t sel_data;
    logic  sel_valid;
    logic  sel_fired;
    logic  hit;
    logic  rearm;

    assign sto_ok = ({1'b0, bus.STO} < DEPTH_W);

    // Compare mux: pick the slot under the scan pointer.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_fired = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (scan_q == idx_t'(i)) begin
                sel_data  = slot_data[i];
                sel_valid = slot_valid[i];
                sel_fired = slot_fired[i];
            end
        end
    end

    assign hit   = sel_valid && (sel_data == bus.Time) && !sel_fired;
    assign rearm = sel_valid && (sel_data != bus.Time);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic sel_this;
            logic addr_this;

            assign sel_this  = (scan_q == idx_t'(gi));
            assign addr_this = sto_ok && (bus.STO == idx_t'(gi));

            alarm_slot u_slot (
                .clk        (Clock),
                .rst        (Clear),
                .wr_en      (bus.Enable && addr_this),
                .erase      (bus.Erase && addr_this),
                .scan_hit   (hit && sel_this),
                .scan_rearm (rearm && sel_this),
                .wr_data    (bus.D),
                .data       (slot_data[gi]),
                .valid      (slot_valid[gi]),
                .fired      (slot_fired[gi])
            );

            assign bus.Q_flat[gi*WIDTH +: WIDTH] = slot_data[gi];
        end
    endgenerate

    // Scan pointer and one-stage Match pipeline.
    always_comb begin
        scan_d      = next_idx(scan_q);
        match_d     = hit;
        match_idx_d = match_idx_q;
        if (hit) begin
            match_idx_d = scan_q;
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            scan_q      <= '0;
            match_q     <= 1'b0;
            match_idx_q <= '0;
        end else begin
            scan_q      <= scan_d;
            match_q     <= match_d;
            match_idx_q <= match_idx_d;
        end
    end

    assign bus.Valid     = slot_valid;
    assign bus.Match     = match_q;
    assign bus.Match_idx = match_idx_q;
    assign bus.Scan_idx  = scan_q;

endmodule

// File: tb/tb_alarm_register_bank.sv
// -----------------------------------------------------------------------------
// tb_alarm_register_bank
// Directed + short random stimulus against alarm_register_bank. A cycle model
// predicts Match/Match_idx per edge into a scoreboard queue; each edge pops
// and compares, and also compares Scan_idx, Valid and Q_flat with the model.
// -----------------------------------------------------------------------------
module tb_alarm_register_bank;
    import alarm_register_bank_pkg::*;

    logic Clock;
    logic Clear;

    alarm_register_bank_if bus ();

    alarm_register_bank dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int total = 0;
    int bad   = 0;

    // Reference model state
    word_t m_data  [DEPTH];
    logic  m_valid [DEPTH];
    logic  m_fired [DEPTH];
    idx_t  m_scan;
    idx_t  m_midx;

    typedef struct {
        logic match;
        idx_t idx;
    } exp_t;

    exp_t sb [$];
    int   match_cnt [DEPTH];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_q();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) r[i*WIDTH +: WIDTH] = m_data[i];
        return r;
    endfunction

    function automatic logic [127:0] model_v();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) r[i] = m_valid[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
            m_fired[i] = 1'b0;
        end
        m_scan = '0;
        m_midx = '0;
        sb.delete();
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < DEPTH; i++) match_cnt[i] = 0;
    endtask

    // One clock: predict from pre-edge inputs, then check after the edge.
    task automatic tick();
        exp_t e;
        exp_t got;
        int   s;
        int   k;
        logic h;
        s = int'(m_scan);
        h = m_valid[s] && (m_data[s] == bus.Time) && !m_fired[s];
        if (h) m_fired[s] = 1'b1;
        else if (m_valid[s] && (m_data[s] != bus.Time)) m_fired[s] = 1'b0;
        if (int'(bus.STO) < DEPTH) begin
            k = int'(bus.STO);
            if (bus.Enable) begin
                m_data[k]  = bus.D;
                m_valid[k] = 1'b1;
                m_fired[k] = 1'b0;
            end
            if (bus.Erase) begin
                m_valid[k] = 1'b0;
                m_fired[k] = 1'b0;
            end
        end
        if (h) m_midx = m_scan;
        m_scan = (s == DEPTH-1) ? idx_t'(0) : idx_t'(s + 1);
        e.match = h;
        e.idx   = m_midx;
        sb.push_back(e);

        @(posedge Clock);
        #1;
        got = sb.pop_front();
        chk("match",     bus.Match,     got.match);
        chk("match_idx", bus.Match_idx, got.idx);
        chk("scan_idx",  bus.Scan_idx,  m_scan);
        chk("valid",     bus.Valid,     model_v());
        chk("q_flat",    bus.Q_flat,    model_q());
        if (bus.Match === 1'b1 && int'(bus.Match_idx) < DEPTH)
            match_cnt[int'(bus.Match_idx)]++;
    endtask

    task automatic drive_idle();
        bus.Enable = 1'b0;
        bus.Erase  = 1'b0;
        bus.STO    = '0;
        bus.D      = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] snap_q;
        logic [127:0] snap_v;
        bit           found;
        word_t        tv;

        Clear    = 1'b1;
        drive_idle();
        bus.Time = '0;
        model_reset();
        clr_cnt();

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_q_flat",    bus.Q_flat,    '0);
        chk("rst_valid",     bus.Valid,     '0);
        chk("rst_match",     bus.Match,     1'b0);
        chk("rst_match_idx", bus.Match_idx, '0);
        chk("rst_scan",      bus.Scan_idx,  '0);
        Clear = 1'b0;
        #1;
        chk("release_scan", bus.Scan_idx, '0);
        repeat (DEPTH + 1) tick();

        // Single match on slot 2 under constant Time
        bus.Time   = 13'h0C1F;
        bus.Enable = 1'b1;
        bus.STO    = idx_t'(2);
        bus.D      = 13'h0C1F;
        tick();
        drive_idle();
        clr_cnt();
        repeat (4*DEPTH) tick();
        chk("one_match_slot2", match_cnt[2], 1);

        // Re-arm after Time moves away for a full scan
        bus.Time = 13'h0C20;
        clr_cnt();
        repeat (DEPTH) tick();
        chk("no_match_moved", match_cnt[2], 0);
        bus.Time = 13'h0C1F;
        clr_cnt();
        repeat (2*DEPTH) tick();
        chk("rearm_match_slot2", match_cnt[2], 1);

        // Write + erase same slot: data stored, valid cleared, no match
        bus.Time   = 13'h0003;
        bus.Enable = 1'b1;
        bus.Erase  = 1'b1;
        bus.STO    = idx_t'(4);
        bus.D      = 13'h0003;
        tick();
        drive_idle();
        clr_cnt();
        repeat (2*DEPTH) tick();
        chk("wr_er_data4",  bus.Q_flat[4*WIDTH +: WIDTH], 13'h0003);
        chk("wr_er_valid4", bus.Valid[4], 1'b0);
        chk("wr_er_nomatch", match_cnt[4], 0);

        // Out-of-range address ignored
        snap_q     = model_q();
        snap_v     = model_v();
        bus.Enable = 1'b1;
        bus.Erase  = 1'b1;
        bus.STO    = idx_t'(7);
        bus.D      = 13'h1FFF;
        tick();
        drive_idle();
        chk("oor_q_flat", bus.Q_flat, snap_q);
        chk("oor_valid",  bus.Valid,  snap_v);

        // Clear pulse while slot 1 has a pending hit
        bus.Time   = 13'h0ABC;
        bus.Enable = 1'b1;
        bus.STO    = idx_t'(1);
        bus.D      = 13'h0ABC;
        tick();
        drive_idle();
        found = 1'b0;
        for (int n = 0; n < 2*DEPTH; n++) begin
            if (bus.Scan_idx == idx_t'(1)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_scan1", found, 1'b1);
        #1;
        Clear = 1'b1;
        #1;
        chk("clr_match",  bus.Match,    1'b0);
        chk("clr_q_flat", bus.Q_flat,   '0);
        chk("clr_valid",  bus.Valid,    '0);
        chk("clr_scan",   bus.Scan_idx, '0);
        #2;
        Clear = 1'b0;
        model_reset();
        #1;
        chk("clr_release_scan", bus.Scan_idx, '0);
        clr_cnt();
        tick();
        chk("clr_suppressed", match_cnt[1], 0);
        repeat (DEPTH) tick();
        chk("clr_write_lost", match_cnt[1], 0);

        // Random traffic, small Time alphabet to provoke matches
        for (int n = 0; n < 80; n++) begin
            tv         = ($urandom_range(0, 1) == 0) ? 13'h0010 : 13'h0011;
            bus.Time   = tv;
            bus.Enable = ($urandom_range(0, 3) == 0);
            bus.Erase  = ($urandom_range(0, 7) == 0);
            bus.STO    = idx_t'($urandom_range(0, 7));
            bus.D      = ($urandom_range(0, 1) == 0) ? 13'h0010 : 13'h0011;
            tick();
        end
        drive_idle();
        repeat (DEPTH) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
